set_packer: RTL and testbench
=============================

// Module: set_packer
// PURPOSE
//  Write-side counterpart of the multi-set ring buffer. Gathers up to IN_NUM_OF_SET result
//  sets per cycle (per-lane valid) from the convolution lanes and packs them into full rows of
//  OUT_NUM_OF_SET sets. Full rows drive the buffer's wen/din under its full_flag backpressure.
//  Partial rows are emitted on flush.
// PARAMETERS
//  DATA_WIDTH      32   bits per element
//  DATA_OF_SET     128  elements per set
//  IN_NUM_OF_SET   3    input lanes per cycle; must be >= 1 and <= OUT_NUM_OF_SET
//  OUT_NUM_OF_SET  16   sets per packed output row
// PORTS
//  clk        in   1                         clock; all logic on posedge
//  rst        in   1                         synchronous, active-high reset
//  din        in   [IN][DOS][DW]             input sets, lane 0 first
//  valid      in   [IN]                      per-lane valid; any mask pattern allowed
//  flush      in   1                         emit current partial row (1-cycle pulse)
//  ready      out  1                         inputs/flush accepted this cycle when 1
//  full_flag  in   1                         downstream buffer full
//  wen        out  1                         output row write strobe
//  dout       out  [OUT][DOS][DW]            packed row
//  wen_mask   out  [OUT]                     set-valid mask of dout (all 1 for a full row)
//  ovf_err    out  1                         sticky drop error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): count=0, accumulator=0, out_valid=0, flush_pend=0, dout=0,
//    wen_mask=0, ovf_err=0. Reset mid-row discards partial data. No wen in the cycle after reset.
//  - Output stage: a registered row with out_valid. wen = out_valid & ~full_flag (comb).
//    The row is consumed when wen=1 and out_valid clears unless a new row loads the same edge.
//    While full_flag=1, dout/wen_mask hold stable.
//  - ready = ~flush_pend & (~out_valid | ~full_flag). It depends combinationally on full_flag.
//  - Accept: when ready & |valid, valid lanes are compacted in ascending lane order.
//    n = popcount(valid). Compacted set k is written to slot (count+k).
//  - Wrap: if count+n >= OUT, slots < OUT complete the row. The completed row loads the output
//    stage next edge with wen_mask all ones. The remaining count+n-OUT sets go to slots 0.. of
//    a cleared accumulator. count <= (count+n) mod OUT. Since OUT>=IN, at most one wrap occurs.
//  - Latency: a completed row appears on wen/dout the cycle after the accepting edge.
//  - Flush (accepted only when ready):
//    - Same-cycle inputs are accepted first.
//    - If no row completes and the post-accept count > 0: emit the partial row next cycle.
//      wen_mask = (1<<count)-1, slots >= count are 0, and count <= 0.
//    - If the post-accept count = 0 (including an exact row completion): the flush is a no-op
//      beyond that row.
//    - If a row completes with remainder r > 0: set flush_pend. The full row is emitted first.
//      Next, the remainder row (wen_mask = (1<<r)-1) loads once the output stage frees.
//      ready = 0 while flush_pend.
//  - FSM: FILL (normal accept) -> FLUSH_PEND (flush with remainder) -> FILL when the remainder
//    row loads into the output stage.
//  - Input while ready=0: data and flush are ignored and not stored.
// CONFIGURATION
//  - SET_PACKER_OVF_EN defined: ovf_err sets at posedge when (|valid | flush) & ~ready.
//    It stays set until rst.
//  - SET_PACKER_OVF_EN undefined: ovf_err is tied to 0 and there is no detection logic.
//    Data path behaviour is identical.
// TESTING (defaults IN=3, OUT=16; set value v = all elements equal v)
//  1. Six beats, valid=3'b111, sets 0..17, full_flag=0 -> one cycle after beat 6: wen=1,
//     dout[j]=j (j=0..15), wen_mask=16'hFFFF; count=2 holding 16,17.
//  2. After reset: valid=3'b101 (lanes 0,2 = 7,9), then 3'b010 (=5) -> slots 0,1,2 = 7,9,5;
//     count=3; no wen.
//  3. Fill a row with full_flag=1 -> wen=0, dout held, ready=0; release full_flag ->
//     same cycle wen=1, ready=1.
//  4. count=5 (sets 0..4), flush=1, valid=0 -> next cycle wen=1, wen_mask=16'h001F,
//     dout[5..15]=0, count=0.
//  5. count=15, valid=3'b111 (a,b,c) + flush -> cycle+1: full row, last=a.
//     cycle+2: row {b,c}, wen_mask=16'h0003. ready=0 for one cycle.
//  6. count=8, rst=1 for one cycle -> no wen ever for those 8 sets. With SET_PACKER_OVF_EN:
//     valid while ready=0 -> ovf_err=1 until rst.

Source files
------------

// File: rtl/set_packer.sv
// set_packer: gathers per-lane result sets and packs them into full rows for the ring buffer.
// Build option SET_PACKER_OVF_EN adds a sticky ovf_err for inputs offered while not ready.
module set_packer #(
   parameter int DATA_WIDTH     = 32,
   parameter int DATA_OF_SET    = 128,
   parameter int IN_NUM_OF_SET  = 3,
   parameter int OUT_NUM_OF_SET = 16
) (
   input  logic                                                       clk,
   input  logic                                                       rst,
   input  logic [IN_NUM_OF_SET-1:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0]  din,
   input  logic [IN_NUM_OF_SET-1:0]                                   valid,
   input  logic                                                       flush,
   output logic                                                       ready,
   input  logic                                                       full_flag,
   output logic                                                       wen,
   output logic [OUT_NUM_OF_SET-1:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0] dout,
   output logic [OUT_NUM_OF_SET-1:0]                                  wen_mask,
   output logic                                                       ovf_err
);

   localparam int CW = $clog2(OUT_NUM_OF_SET + 1);
   localparam int SW = CW + 1;
   localparam int IW = (OUT_NUM_OF_SET > 1) ? $clog2(OUT_NUM_OF_SET) : 1;
   localparam logic [SW-1:0] OUT_S = SW'(OUT_NUM_OF_SET);

   typedef logic [OUT_NUM_OF_SET-1:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0] row_t;
   typedef enum logic {FILL, FLUSH_PEND} state_t;

   state_t                    state;
   state_t                    next_state;
   row_t                      acc;
   row_t                      acc_next;
   row_t                      row_next;
   row_t                      rem_next;
   row_t                      load_row;
   logic [CW-1:0]             count;
   logic [CW-1:0]             count_next;
   logic [SW-1:0]             pos;
   logic [SW-1:0]             sum;
   logic                      out_valid;
   logic                      load_out;
   logic                      wrap;
   logic                      stage_free;
   logic [OUT_NUM_OF_SET-1:0] load_mask;

   function automatic logic [OUT_NUM_OF_SET-1:0] low_mask(input logic [SW-1:0] n);
      logic [OUT_NUM_OF_SET-1:0] m;
      m = '0;
      for (int i = 0; i < OUT_NUM_OF_SET; i++) begin
         m[i] = (SW'(i) < n);
      end
      return m;
   endfunction

   assign stage_free = ~out_valid | ~full_flag;
   assign ready      = (state == FILL) & stage_free;
   assign wen        = out_valid & ~full_flag;

   // Compact accepted lanes into slots count.. ; sets past the row end spill into a fresh row.
   always_comb begin
      row_next = acc;
      rem_next = '0;
      pos      = {1'b0, count};
      for (int i = 0; i < IN_NUM_OF_SET; i++) begin
         if (ready && valid[i]) begin
            if (pos < OUT_S) begin
               row_next[IW'(pos)] = din[i];
            end else begin
               rem_next[IW'(pos - OUT_S)] = din[i];
            end
            pos = pos + SW'(1);
         end
      end
      sum  = pos;
      wrap = (sum >= OUT_S);
   end

   always_comb begin
      next_state = state;
      load_out   = 1'b0;
      load_row   = row_next;
      load_mask  = '0;
      acc_next   = acc;
      count_next = count;
      case (state)
         FILL: begin
            if (ready) begin
               if (wrap) begin
                  load_out   = 1'b1;
                  load_mask  = '1;
                  acc_next   = rem_next;
                  count_next = CW'(sum - OUT_S);
                  if (flush && (sum != OUT_S)) begin
                     next_state = FLUSH_PEND;
                  end
               end else if (flush && (sum != '0)) begin
                  load_out   = 1'b1;
                  load_mask  = low_mask(sum);
                  acc_next   = '0;
                  count_next = '0;
               end else begin
                  acc_next   = row_next;
                  count_next = CW'(sum);
               end
            end
         end
         FLUSH_PEND: begin
            // The remainder waits in the accumulator until the full row ahead of it leaves.
            if (stage_free) begin
               load_out   = 1'b1;
               load_row   = acc;
               load_mask  = low_mask({1'b0, count});
               acc_next   = '0;
               count_next = '0;
               next_state = FILL;
            end
         end
         default: next_state = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FILL;
      end else begin
         state <= next_state;
      end
   end

   // Output stage holds its row steady until the buffer accepts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         dout      <= '0;
         wen_mask  <= '0;
      end else begin
         acc   <= acc_next;
         count <= count_next;
         if (load_out) begin
            out_valid <= 1'b1;
            dout      <= load_row;
            wen_mask  <= load_mask;
         end else if (wen) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef SET_PACKER_OVF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_err <= 1'b0;
      end else if ((|valid | flush) & ~ready) begin
         ovf_err <= 1'b1;
      end
   end
`else
   assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_set_packer.sv
// tb_set_packer: random traffic against a queue-based packing model with a scoreboarded monitor.
// Expected ovf_err follows SET_PACKER_OVF_EN.
module tb_set_packer;

   localparam int DW     = 32;
   localparam int DOS    = 128;
   localparam int IN     = 3;
   localparam int OUT    = 16;
   localparam int CYCLES = 3000;

   typedef logic [DOS-1:0][DW-1:0] set_t;
   typedef logic [OUT-1:0][DOS-1:0][DW-1:0] row_vec_t;
   typedef struct packed {
      logic [OUT-1:0][31:0] val;
      logic [OUT-1:0]       mask;
   } exp_row_t;

   logic                           clk = 1'b0;
   logic                           rst;
   logic [IN-1:0][DOS-1:0][DW-1:0] din;
   logic [IN-1:0]                  valid;
   logic                           flush;
   logic                           ready;
   logic                           full_flag;
   logic                           wen;
   row_vec_t                       dout;
   logic [OUT-1:0]                 wen_mask;
   logic                           ovf_err;

   int          vectors     = 0;
   int          miscompares = 0;
   bit          mon_en      = 1'b0;
   bit          ovf_model   = 1'b0;
   exp_row_t    sb[$];
   exp_row_t    staged[$];
   logic [31:0] pend[$];

   set_packer #(
      .DATA_WIDTH(DW), .DATA_OF_SET(DOS), .IN_NUM_OF_SET(IN), .OUT_NUM_OF_SET(OUT)
   ) dut (
      .clk(clk), .rst(rst), .din(din), .valid(valid), .flush(flush), .ready(ready),
      .full_flag(full_flag), .wen(wen), .dout(dout), .wen_mask(wen_mask), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   function automatic set_t mk_set(input logic [31:0] v);
      set_t s;
      for (int e = 0; e < DOS; e++) s[e] = v ^ DW'(e);
      return s;
   endfunction

   function automatic row_vec_t expand(input exp_row_t r);
      row_vec_t v;
      v = '0;
      for (int k = 0; k < OUT; k++) if (r.mask[k]) v[k] = mk_set(r.val[k]);
      return v;
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic stage_row(input int n);
      exp_row_t r;
      r = '0;
      for (int k = 0; k < n; k++) begin
         r.val[k]  = pend.pop_front();
         r.mask[k] = 1'b1;
      end
      staged.push_back(r);
   endtask

   // Monitor: whenever a row sits in the output stage it must match the oldest expected row.
   initial begin
      exp_row_t er;
      row_vec_t ev;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en) begin
            check_output("wen", 64'(wen), 64'(sb.size() > 0 && !full_flag));
            if (sb.size() > 0) begin
               er = sb[0];
               ev = expand(er);
               vectors++;
               if (dout !== ev || wen_mask !== er.mask) begin
                  miscompares++;
                  for (int k = 0; k < OUT; k++) begin
                     if (dout[k] !== ev[k] || k == OUT - 1) begin
                        $display("[TB] FAIL row: slot %0d got 0x%0h expected 0x%0h, mask got 0x%0h expected 0x%0h",
                                 k, dout[k][0], ev[k][0], wen_mask, er.mask);
                        break;
                     end
                  end
               end
               if (wen) void'(sb.pop_front());
            end
         end
      end
   end

   task automatic apply_stimulus(input bit do_rst, input bit idle);
      logic [IN-1:0][31:0] lane_val;
      bit                  model_ready;
      bit                  exp_ovf;
      @(negedge clk);
      rst       = do_rst;
      full_flag = idle ? 1'b0 : ($urandom_range(0, 3) == 0);
      valid     = (do_rst || idle) ? '0 : IN'($urandom);
      flush     = !do_rst && !idle && ($urandom_range(0, 7) == 0);
      for (int i = 0; i < IN; i++) begin
         lane_val[i] = $urandom;
         din[i]      = mk_set(lane_val[i]);
      end
      model_ready = (sb.size() == 0) || (sb.size() == 1 && !full_flag);
      #1;
      if (!do_rst) begin
         check_output("ready", 64'(ready), 64'(model_ready));
         if (model_ready) begin
            for (int i = 0; i < IN; i++) if (valid[i]) pend.push_back(lane_val[i]);
            while (pend.size() >= OUT) stage_row(OUT);
            if (flush && pend.size() > 0) stage_row(pend.size());
         end else if (valid != '0 || flush) begin
            ovf_model = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      if (do_rst) begin
         pend.delete();
         staged.delete();
         sb.delete();
         ovf_model = 1'b0;
         vectors++;
         if (dout !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_dout: got 0x%0h in slot 0, expected all zero", dout[0][0]);
         end
         check_output("reset_mask", 64'(wen_mask), 64'(0));
         check_output("reset_wen", 64'(wen), 64'(0));
      end else begin
         while (staged.size() > 0) sb.push_back(staged.pop_front());
      end
`ifdef SET_PACKER_OVF_EN
      exp_ovf = ovf_model;
`else
      exp_ovf = 1'b0;
`endif
      check_output("ovf_err", 64'(ovf_err), 64'(exp_ovf));
   endtask

   initial begin
      rst       = 1'b1;
      valid     = '0;
      flush     = 1'b0;
      full_flag = 1'b0;
      din       = '0;
      apply_stimulus(1'b1, 1'b1);
      apply_stimulus(1'b1, 1'b1);
      mon_en = 1'b1;
      for (int c = 0; c < CYCLES; c++) begin
         apply_stimulus($urandom_range(0, 249) == 0, 1'b0);
      end
      for (int c = 0; c < 6; c++) apply_stimulus(1'b0, 1'b1);
      check_output("drain", 64'(sb.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
